dispense_sequencer: RTL and testbench
=====================================

Name: dispense_sequencer

Overview:
- Downstream consumer of the 3-to-8 slot decoder's one-hot outputs.
- On a vend strobe from the payment/subtractor path, it validates the one-hot slot select and checks per-slot stock.
- It then drives the selected slot's motor for a fixed pulse and reports completion.
- Holds an 8-entry stock counter bank; restocking goes through the same select lines.

Parameters:
- PULSE_CYCLES, 50000, clock cycles the motor output is held high per dispense (must be >= 1).
- STOCK_W, 4, width of each per-slot stock counter.
- STOCK_INIT, 5, value loaded into every stock counter at reset and on restock (must be < 2**STOCK_W).
- COOLDOWN_CYCLES, 16, post-dispense lockout length; used only with the optional feature.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- SEL  input  8  one-hot slot select from the decoder; bit i corresponds to decoder output Yi.
- VEND  input  1  single-cycle request to dispense the slot on SEL.
- RESTOCK  input  1  single-cycle request to reload the stock of every slot whose SEL bit is set.
- MOTOR  output  8  one-hot motor drive; high for PULSE_CYCLES during a dispense.
- BUSY  output  1  high while a dispense (or cooldown) is in progress.
- DONE  output  1  one-cycle pulse when a dispense completes.
- FAULT  output  1  one-cycle pulse when a VEND is rejected.
- SOLD_OUT  output  8  bit i high when stock[i] == 0.

Behaviour:
- Clock and reset: one clock, CLK; reset RST is synchronous, active-high.
- Reset values:
  - State IDLE; MOTOR = 0, BUSY = 0, DONE = 0, FAULT = 0.
  - All stock[i] = STOCK_INIT; SOLD_OUT = 0.
  - Cycle counter = 0.
- States: IDLE, DISPENSE, FINISH (plus COOLDOWN when the feature is enabled).
- IDLE, RESTOCK = 1:
  - Every slot i with SEL[i] = 1 loads STOCK_INIT next edge; SEL = 0 is a no-op.
  - RESTOCK has priority over VEND in the same cycle; that VEND is dropped with no FAULT.
- IDLE, VEND = 1 (RESTOCK = 0): SEL is registered into sel_q.
  - If SEL is not exactly one-hot (zero or multi-hot) -> FAULT = 1 next cycle for one cycle; stay IDLE.
  - Else if stock of the selected slot == 0 -> FAULT pulse; stay IDLE.
  - Else -> DISPENSE; the selected stock counter decrements by 1 on the same edge.
- DISPENSE:
  - MOTOR = sel_q; BUSY = 1; the counter counts 1..PULSE_CYCLES.
  - After the PULSE_CYCLES-th cycle -> FINISH.
- FINISH: MOTOR = 0; DONE = 1; BUSY = 1; lasts one cycle, then -> IDLE.
- Latency for a valid VEND sampled at edge n:
  - MOTOR high for cycles n+1 .. n+PULSE_CYCLES.
  - DONE at cycle n+PULSE_CYCLES+1.
  - The earliest next VEND is accepted at edge n+PULSE_CYCLES+2.
- VEND or RESTOCK outside IDLE: ignored silently (no FAULT, no stock change).
- SEL changes during DISPENSE have no effect; sel_q is held.
- Stock never underflows (zero is rejected before the decrement); no wrap-around.
- SOLD_OUT is a combinational decode of the stock registers, so it updates the cycle after a decrement or reload.
- RST mid-DISPENSE: MOTOR drops and all outputs return to reset values at that edge; stock is reloaded to STOCK_INIT.
- MOTOR always has at most one bit set.

Optional Feature:
- Macro: VEND_COOLDOWN_EN.
- Defined:
  - FINISH goes to COOLDOWN instead of IDLE; COOLDOWN lasts COOLDOWN_CYCLES cycles.
  - During COOLDOWN: BUSY = 1, MOTOR = 0, VEND and RESTOCK are ignored; then -> IDLE.
  - Next-accept latency grows by COOLDOWN_CYCLES.
- Undefined: the COOLDOWN state and its counter are absent; FINISH returns directly to IDLE.

Test Plan (PULSE_CYCLES = 4, STOCK_INIT = 2, STOCK_W = 4):
- Reset, SEL = 8'h04, VEND one cycle -> MOTOR = 8'h04 for exactly 4 cycles, DONE pulse on the 5th cycle, BUSY high for 5 cycles, SOLD_OUT = 0.
- Three valid vends on SEL = 8'h01, each after DONE -> first two dispense; after the second, SOLD_OUT[0] = 1; the third gives a FAULT pulse and MOTOR stays 0.
- VEND with SEL = 8'h00, then SEL = 8'h12 -> one FAULT pulse each, no MOTOR activity, stock unchanged.
- During DISPENSE on slot 3, pulse VEND with SEL = 8'h80 and RESTOCK -> ignored: MOTOR remains 8'h08, no FAULT, stock[7] unchanged.
- Drain slot 0 to SOLD_OUT[0] = 1, then RESTOCK with SEL = 8'h01 together with VEND -> stock[0] = 2, SOLD_OUT[0] = 0, no dispense, no FAULT.
- Assert RST on the 2nd MOTOR cycle of a dispense -> next cycle MOTOR = 0, BUSY = 0, DONE never pulses, all stock back to 2.

Source files
------------

// File: rtl/dispense_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dispense_sequencer
// Brief    : Validates a one-hot slot select on VEND, checks per-slot stock and
//            drives the slot motor for a fixed pulse. Optional post-dispense
//            lockout is enabled with the VEND_COOLDOWN_EN macro.
// Revision : 1.0
// ============================================================================
module dispense_sequencer #(
    parameter int unsigned PULSE_CYCLES    = 50000,
    parameter int unsigned STOCK_W         = 4,
    parameter int unsigned STOCK_INIT      = 5,
    parameter int unsigned COOLDOWN_CYCLES = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] SEL,
    input  logic       VEND,
    input  logic       RESTOCK,
    output logic [7:0] MOTOR,
    output logic       BUSY,
    output logic       DONE,
    output logic       FAULT,
    output logic [7:0] SOLD_OUT
);

    localparam int unsigned CNT_W = $clog2(PULSE_CYCLES + 1);
`ifdef VEND_COOLDOWN_EN
    localparam int unsigned CD_W  = $clog2(COOLDOWN_CYCLES + 1);
`endif

    if (PULSE_CYCLES < 1 || COOLDOWN_CYCLES < 1 || STOCK_INIT >= (2 ** STOCK_W)) begin : g_param_check
        $error("dispense_sequencer: illegal parameter combination");
    end

`ifdef VEND_COOLDOWN_EN
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        FINISH   = 2'd2,
        COOLDOWN = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        FINISH   = 2'd2
    } state_t;
`endif

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [7:0]         r_sel_q;
    logic [STOCK_W-1:0] r_stock [8];
`ifdef VEND_COOLDOWN_EN
    logic [CD_W-1:0]    r_cd_cnt;
`endif

    logic w_onehot;
    logic w_sel_empty;

    assign w_onehot    = (SEL != 8'd0) && ((SEL & (SEL - 8'd1)) == 8'd0);
    assign w_sel_empty = |(SEL & SOLD_OUT);

    for (genvar gi = 0; gi < 8; gi++) begin : g_sold_out
        assign SOLD_OUT[gi] = (r_stock[gi] == '0);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sel_q <= 8'd0;
            MOTOR   <= 8'd0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            FAULT   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_stock[i] <= STOCK_W'(STOCK_INIT);
            end
`ifdef VEND_COOLDOWN_EN
            r_cd_cnt <= '0;
`endif
        end else begin
            DONE  <= 1'b0;
            FAULT <= 1'b0;
            case (r_state)
                IDLE: begin
                    // RESTOCK wins over a simultaneous VEND, which is dropped silently.
                    if (RESTOCK) begin
                        for (int i = 0; i < 8; i++) begin
                            if (SEL[i]) r_stock[i] <= STOCK_W'(STOCK_INIT);
                        end
                    end else if (VEND) begin
                        r_sel_q <= SEL;
                        if (!w_onehot || w_sel_empty) begin
                            FAULT <= 1'b1;
                        end else begin
                            r_state <= DISPENSE;
                            MOTOR   <= SEL;
                            BUSY    <= 1'b1;
                            r_cnt   <= CNT_W'(1);
                            for (int i = 0; i < 8; i++) begin
                                if (SEL[i]) r_stock[i] <= r_stock[i] - STOCK_W'(1);
                            end
                        end
                    end
                end
                DISPENSE: begin
                    MOTOR <= r_sel_q;
                    if (r_cnt == CNT_W'(PULSE_CYCLES)) begin
                        r_state <= FINISH;
                        MOTOR   <= 8'd0;
                        DONE    <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                FINISH: begin
`ifdef VEND_COOLDOWN_EN
                    r_state  <= COOLDOWN;
                    r_cd_cnt <= CD_W'(1);
`else
                    r_state <= IDLE;
                    BUSY    <= 1'b0;
`endif
                end
`ifdef VEND_COOLDOWN_EN
                COOLDOWN: begin
                    if (r_cd_cnt == CD_W'(COOLDOWN_CYCLES)) begin
                        r_state  <= IDLE;
                        BUSY     <= 1'b0;
                        r_cd_cnt <= '0;
                    end else begin
                        r_cd_cnt <= r_cd_cnt + CD_W'(1);
                    end
                end
`endif
                default: begin
                    r_state <= IDLE;
                    MOTOR   <= 8'd0;
                    BUSY    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dispense_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dispense_sequencer
// Brief    : Directed self-checking bench for dispense_sequencer (P=4, INIT=2).
// Revision : 1.0
// ============================================================================
module tb_dispense_sequencer;

    localparam int P = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] SEL = 8'd0;
    logic       VEND = 1'b0;
    logic       RESTOCK = 1'b0;
    logic [7:0] MOTOR;
    logic       BUSY;
    logic       DONE;
    logic       FAULT;
    logic [7:0] SOLD_OUT;

    int total = 0;
    int bad   = 0;

    dispense_sequencer #(
        .PULSE_CYCLES   (P),
        .STOCK_W        (4),
        .STOCK_INIT     (2),
        .COOLDOWN_CYCLES(16)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .SEL      (SEL),
        .VEND     (VEND),
        .RESTOCK  (RESTOCK),
        .MOTOR    (MOTOR),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .FAULT    (FAULT),
        .SOLD_OUT (SOLD_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; VEND = 1'b0; RESTOCK = 1'b0; SEL = 8'd0;
        tick();
        tick();
        RST = 1'b0;
    endtask

    // Single-cycle VEND; returns in the first cycle after the sampling edge.
    task automatic vend(input logic [7:0] s);
        SEL = s; VEND = 1'b1;
        tick();
        VEND = 1'b0; SEL = 8'd0;
    endtask

    // Full accepted dispense; returns back in IDLE.
    task automatic run_dispense(input logic [7:0] s);
        vend(s);
        repeat (P + 1) tick();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (MOTOR !== 8'd0)    begin bad++; $display("FAIL reset_motor got=%h exp=00", MOTOR); end
        total++; if (BUSY !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
        total++; if (DONE !== 1'b0)     begin bad++; $display("FAIL reset_done got=%b exp=0", DONE); end
        total++; if (FAULT !== 1'b0)    begin bad++; $display("FAIL reset_fault got=%b exp=0", FAULT); end
        total++; if (SOLD_OUT !== 8'd0) begin bad++; $display("FAIL reset_sold_out got=%h exp=00", SOLD_OUT); end
    endtask

    task automatic test_single_dispense();
        do_reset();
        vend(8'h04);
        for (int k = 0; k < P; k++) begin
            total++; if (MOTOR !== 8'h04) begin bad++; $display("FAIL single_motor c%0d got=%h exp=04", k, MOTOR); end
            total++; if (BUSY !== 1'b1)   begin bad++; $display("FAIL single_busy c%0d got=%b exp=1", k, BUSY); end
            total++; if (DONE !== 1'b0)   begin bad++; $display("FAIL single_done_early c%0d got=%b exp=0", k, DONE); end
            tick();
        end
        total++; if (MOTOR !== 8'h00) begin bad++; $display("FAIL single_motor_finish got=%h exp=00", MOTOR); end
        total++; if (DONE !== 1'b1)   begin bad++; $display("FAIL single_done got=%b exp=1", DONE); end
        total++; if (BUSY !== 1'b1)   begin bad++; $display("FAIL single_busy_finish got=%b exp=1", BUSY); end
        tick();
        total++; if (DONE !== 1'b0)   begin bad++; $display("FAIL single_done_width got=%b exp=0", DONE); end
        total++; if (BUSY !== 1'b0)   begin bad++; $display("FAIL single_busy_idle got=%b exp=0", BUSY); end
        total++; if (SOLD_OUT !== 8'd0) begin bad++; $display("FAIL single_sold_out got=%h exp=00", SOLD_OUT); end
        total++; if (dut.r_stock[2] !== 4'd1) begin bad++; $display("FAIL single_stock2 got=%0d exp=1", dut.r_stock[2]); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        run_dispense(8'h40);
        vend(8'h40);
        total++; if (MOTOR !== 8'h40) begin bad++; $display("FAIL b2b_accept got=%h exp=40", MOTOR); end
        total++; if (FAULT !== 1'b0)  begin bad++; $display("FAIL b2b_fault got=%b exp=0", FAULT); end
        repeat (P + 1) tick();
        total++; if (SOLD_OUT !== 8'h40) begin bad++; $display("FAIL b2b_sold_out got=%h exp=40", SOLD_OUT); end
    endtask

    task automatic test_sold_out();
        do_reset();
        run_dispense(8'h01);
        total++; if (SOLD_OUT[0] !== 1'b0) begin bad++; $display("FAIL sold_after_first got=%b exp=0", SOLD_OUT[0]); end
        run_dispense(8'h01);
        total++; if (SOLD_OUT[0] !== 1'b1) begin bad++; $display("FAIL sold_after_second got=%b exp=1", SOLD_OUT[0]); end
        vend(8'h01);
        total++; if (FAULT !== 1'b1)  begin bad++; $display("FAIL sold_fault got=%b exp=1", FAULT); end
        total++; if (MOTOR !== 8'h00) begin bad++; $display("FAIL sold_motor got=%h exp=00", MOTOR); end
        total++; if (BUSY !== 1'b0)   begin bad++; $display("FAIL sold_busy got=%b exp=0", BUSY); end
        tick();
        total++; if (FAULT !== 1'b0)  begin bad++; $display("FAIL sold_fault_width got=%b exp=0", FAULT); end
        total++; if (dut.r_stock[0] !== 4'd0) begin bad++; $display("FAIL sold_no_underflow got=%0d exp=0", dut.r_stock[0]); end
    endtask

    task automatic test_bad_select();
        do_reset();
        vend(8'h00);
        total++; if (FAULT !== 1'b1)  begin bad++; $display("FAIL badsel_zero_fault got=%b exp=1", FAULT); end
        total++; if (MOTOR !== 8'h00) begin bad++; $display("FAIL badsel_zero_motor got=%h exp=00", MOTOR); end
        tick();
        total++; if (FAULT !== 1'b0)  begin bad++; $display("FAIL badsel_zero_width got=%b exp=0", FAULT); end
        vend(8'h12);
        total++; if (FAULT !== 1'b1)  begin bad++; $display("FAIL badsel_multi_fault got=%b exp=1", FAULT); end
        total++; if (MOTOR !== 8'h00) begin bad++; $display("FAIL badsel_multi_motor got=%h exp=00", MOTOR); end
        total++; if (BUSY !== 1'b0)   begin bad++; $display("FAIL badsel_multi_busy got=%b exp=0", BUSY); end
        tick();
        total++; if (dut.r_stock[1] !== 4'd2 || dut.r_stock[4] !== 4'd2)
            begin bad++; $display("FAIL badsel_stock got=%0d/%0d exp=2/2", dut.r_stock[1], dut.r_stock[4]); end
    endtask

    task automatic test_ignore_busy();
        do_reset();
        vend(8'h08);
        SEL = 8'h80; VEND = 1'b1; RESTOCK = 1'b1;
        tick();
        VEND = 1'b0; RESTOCK = 1'b0; SEL = 8'h00;
        total++; if (MOTOR !== 8'h08) begin bad++; $display("FAIL busy_motor got=%h exp=08", MOTOR); end
        total++; if (FAULT !== 1'b0)  begin bad++; $display("FAIL busy_fault got=%b exp=0", FAULT); end
        tick();
        total++; if (MOTOR !== 8'h08) begin bad++; $display("FAIL busy_motor_hold got=%h exp=08", MOTOR); end
        repeat (P) tick();
        total++; if (dut.r_stock[7] !== 4'd2) begin bad++; $display("FAIL busy_stock7 got=%0d exp=2", dut.r_stock[7]); end
        total++; if (dut.r_stock[3] !== 4'd1) begin bad++; $display("FAIL busy_stock3 got=%0d exp=1", dut.r_stock[3]); end
        total++; if (BUSY !== 1'b0)   begin bad++; $display("FAIL busy_end got=%b exp=0", BUSY); end
    endtask

    task automatic test_restock_priority();
        do_reset();
        run_dispense(8'h01);
        run_dispense(8'h01);
        total++; if (SOLD_OUT[0] !== 1'b1) begin bad++; $display("FAIL restock_drained got=%b exp=1", SOLD_OUT[0]); end
        SEL = 8'h01; VEND = 1'b1; RESTOCK = 1'b1;
        tick();
        VEND = 1'b0; RESTOCK = 1'b0; SEL = 8'h00;
        total++; if (dut.r_stock[0] !== 4'd2) begin bad++; $display("FAIL restock_stock0 got=%0d exp=2", dut.r_stock[0]); end
        total++; if (SOLD_OUT[0] !== 1'b0) begin bad++; $display("FAIL restock_sold_out got=%b exp=0", SOLD_OUT[0]); end
        total++; if (MOTOR !== 8'h00) begin bad++; $display("FAIL restock_motor got=%h exp=00", MOTOR); end
        total++; if (FAULT !== 1'b0)  begin bad++; $display("FAIL restock_fault got=%b exp=0", FAULT); end
        total++; if (BUSY !== 1'b0)   begin bad++; $display("FAIL restock_busy got=%b exp=0", BUSY); end
    endtask

    task automatic test_reset_mid_dispense();
        logic saw_done;
        do_reset();
        run_dispense(8'h02);
        vend(8'h20);
        tick();
        total++; if (MOTOR !== 8'h20) begin bad++; $display("FAIL rstmid_motor_pre got=%h exp=20", MOTOR); end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        total++; if (MOTOR !== 8'h00) begin bad++; $display("FAIL rstmid_motor got=%h exp=00", MOTOR); end
        total++; if (BUSY !== 1'b0)   begin bad++; $display("FAIL rstmid_busy got=%b exp=0", BUSY); end
        saw_done = 1'b0;
        for (int k = 0; k < P + 3; k++) begin
            if (DONE === 1'b1) saw_done = 1'b1;
            tick();
        end
        total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b exp=0", saw_done); end
        total++; if (dut.r_stock[5] !== 4'd2 || dut.r_stock[1] !== 4'd2)
            begin bad++; $display("FAIL rstmid_stock got=%0d/%0d exp=2/2", dut.r_stock[5], dut.r_stock[1]); end
    endtask

    initial begin
        test_reset();
        test_single_dispense();
        test_back_to_back();
        test_sold_out();
        test_bad_select();
        test_ignore_busy();
        test_restock_priority();
        test_reset_mid_dispense();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
